vga_sram_arbiter: RTL and testbench

- Owns the single 16-bit async SRAM frame buffer on the board and shares it between two requesters.
- Requester 1 is the VGA timing core's render-request stream: pixel (H,V), 1-based, issued 2 cycles ahead of RGB output.
- Requester 2 is a drawing engine writing RGB565 pixels through a valid/ready port.
- VGA reads have absolute priority; writes use idle cycles (blanking, porches). Frame buffer is stored at 1/2^SCALE_SHIFT resolution and pixel-replicated on readout.

---
 rtl/vga_sram_pkg.sv | 22 ++
 rtl/sram_addr_gen.sv | 30 +++
 rtl/vga_sram_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_vga_sram_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sram_pkg.sv
// Shared types and helpers for the VGA frame-buffer SRAM arbiter.
// No state; pure declarations.
// No flow control.
package vga_sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  // Encoding keeps every transition into or out of S_WRITE from passing
  // through S_WRITE, so the decoded WE_N cannot glitch low.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } bus_state_e;

  // RGB565 -> RGB888 by replicating the top bits of each channel into the LSBs.
  function automatic logic [23:0] rgb565_to_888(input logic [SRAM_DATA_W-1:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

endpackage

// File: rtl/sram_addr_gen.sv
// Coordinate (1-based) to linear SRAM address with range check.
// Latency: combinational.
// No flow control.
module sram_addr_gen
  import vga_sram_pkg::*;
#(
  parameter int MAX_COL   = 800,
  parameter int MAX_ROW   = 450,
  parameter int SHIFT     = 0,
  parameter int ROW_PITCH = 800
) (
  input  logic [11:0]            i_col,
  input  logic [10:0]            i_row,
  output logic [SRAM_ADDR_W-1:0] o_addr,
  output logic                   o_ok
);

  logic [31:0] w_col_idx;
  logic [31:0] w_row_idx;

  // Zero-based, downscaled indices; garbage when the coordinate is 0, but o_ok masks that.
  assign w_col_idx = (32'(i_col) - 32'd1) >> SHIFT;
  assign w_row_idx = (32'(i_row) - 32'd1) >> SHIFT;

  assign o_addr = SRAM_ADDR_W'(w_row_idx * 32'(ROW_PITCH) + w_col_idx);

  assign o_ok = (i_col != '0) && (i_row != '0) &&
                (32'(i_col) <= 32'(MAX_COL)) && (32'(i_row) <= 32'(MAX_ROW));

endmodule

// File: rtl/vga_sram_arbiter.sv
// Shares one async 16-bit SRAM between VGA pixel reads and a drawing-engine write port.
// Latency: VGA colour READ_LATENCY cycles after request; writes hit SRAM the cycle after accept when no read.
// Backpressure: reads never stall; o_wr_ready drops while a pending write is blocked by reads.
module vga_sram_arbiter
  import vga_sram_pkg::*;
#(
  parameter int H_SIZE       = 1600,
  parameter int V_SIZE       = 900,
  parameter int SCALE_SHIFT  = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [11:0] i_vga_H,
  input  logic [10:0] i_vga_V,
  input  logic        i_vga_valid,
  output logic [23:0] o_vga_color,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic [11:0] i_wr_x,
  input  logic [10:0] i_wr_y,
  input  logic [15:0] i_wr_data,
  output logic [15:0] o_wr_drop_count,
  output logic [19:0] o_SRAM_ADDR,
  inout  wire  [15:0] io_SRAM_DQ,
  output logic        o_SRAM_WE_N,
  output logic        o_SRAM_CE_N,
  output logic        o_SRAM_OE_N,
  output logic        o_SRAM_LB_N,
  output logic        o_SRAM_UB_N
);

  localparam int FB_W = H_SIZE >> SCALE_SHIFT;
  localparam int FB_H = V_SIZE >> SCALE_SHIFT;

  bus_state_e r_state;
  bus_state_e w_state_nxt;

  logic [SRAM_ADDR_W-1:0] w_rd_addr;
  logic                   w_rd_ok;
  logic [SRAM_ADDR_W-1:0] w_wr_addr;
  logic                   w_wr_ok;

  logic                   r_slot_vld;
  logic [SRAM_ADDR_W-1:0] r_slot_addr;
  logic [SRAM_DATA_W-1:0] r_slot_dat;

  logic [SRAM_ADDR_W-1:0] r_addr;
  logic [SRAM_DATA_W-1:0] r_wdat;
  logic [15:0]            r_drop_cnt;
  logic [23:0]            r_color_pipe [READ_LATENCY-1];

  logic w_issue;
  logic w_wr_acc;
  logic w_wr_take;
  logic w_wr_drop;
  logic w_slot_full_nxt;
  logic w_rd_go;
  logic w_ce_n;
  logic w_oe_n;
  logic w_we_n;
  logic w_be_n;
  logic w_dq_oe;

  sram_addr_gen #(
    .MAX_COL  (H_SIZE),
    .MAX_ROW  (V_SIZE),
    .SHIFT    (SCALE_SHIFT),
    .ROW_PITCH(FB_W)
  ) u_rd_addr (
    .i_col (i_vga_H),
    .i_row (i_vga_V),
    .o_addr(w_rd_addr),
    .o_ok  (w_rd_ok)
  );

  sram_addr_gen #(
    .MAX_COL  (FB_W),
    .MAX_ROW  (FB_H),
    .SHIFT    (0),
    .ROW_PITCH(FB_W)
  ) u_wr_addr (
    .i_col (i_wr_x),
    .i_row (i_wr_y),
    .o_addr(w_wr_addr),
    .o_ok  (w_wr_ok)
  );

  // The slot drains at the end of an S_WRITE cycle, so it can take a new write in that same cycle.
  assign w_issue         = (r_state == S_WRITE);
  assign o_wr_ready      = !r_slot_vld || w_issue;
  assign w_wr_acc        = i_wr_valid && o_wr_ready;
  assign w_wr_take       = w_wr_acc && w_wr_ok;
  assign w_wr_drop       = w_wr_acc && !w_wr_ok;
  assign w_slot_full_nxt = w_wr_take || (r_slot_vld && !w_issue);
  // Out-of-range pixels never touch the bus, leaving the cycle free for a write.
  assign w_rd_go         = i_vga_valid && w_rd_ok;

  // Bus state register; reset drops any in-flight strobe immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next bus state: reads always win, a pending write waits indefinitely.
  always_comb begin
    w_state_nxt = S_IDLE;
    if (w_rd_go)              w_state_nxt = S_READ;
    else if (w_slot_full_nxt) w_state_nxt = S_WRITE;
  end

  // SRAM strobes decoded from the bus state.
  always_comb begin
    w_ce_n  = 1'b1;
    w_oe_n  = 1'b1;
    w_we_n  = 1'b1;
    w_be_n  = 1'b1;
    w_dq_oe = 1'b0;
    case (r_state)
      S_READ: begin
        w_ce_n = 1'b0;
        w_oe_n = 1'b0;
        w_be_n = 1'b0;
      end
      S_WRITE: begin
        w_ce_n  = 1'b0;
        w_we_n  = 1'b0;
        w_be_n  = 1'b0;
        w_dq_oe = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_SRAM_CE_N = w_ce_n;
  assign o_SRAM_OE_N = w_oe_n;
  assign o_SRAM_WE_N = w_we_n;
  assign o_SRAM_LB_N = w_be_n;
  assign o_SRAM_UB_N = w_be_n;
  assign o_SRAM_ADDR = r_addr;
  // DQ is released on the same edge that raises WE_N, so a following read never overlaps.
  assign io_SRAM_DQ  = w_dq_oe ? r_wdat : 'z;

  // Pending write slot: loads on an in-range accept, clears once issued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot_vld  <= 1'b0;
      r_slot_addr <= '0;
      r_slot_dat  <= '0;
    end else if (w_wr_take) begin
      r_slot_vld  <= 1'b1;
      r_slot_addr <= w_wr_addr;
      r_slot_dat  <= i_wr_data;
    end else if (w_issue) begin
      r_slot_vld  <= 1'b0;
    end
  end

  // Address/data registers for the next bus cycle; a fresh accept bypasses the slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
      r_wdat <= '0;
    end else if (w_rd_go) begin
      r_addr <= w_rd_addr;
    end else if (w_slot_full_nxt) begin
      r_addr <= w_wr_take ? w_wr_addr : r_slot_addr;
      r_wdat <= w_wr_take ? i_wr_data : r_slot_dat;
    end
  end

  // Saturating count of discarded out-of-range writes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                             r_drop_cnt <= '0;
    else if (w_wr_drop && r_drop_cnt != '1)   r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign o_wr_drop_count = r_drop_cnt;

  // Capture DQ at the end of the read cycle; extra stages stretch to the VGA core's lookahead.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < READ_LATENCY - 1; i++) r_color_pipe[i] <= '0;
    end else begin
      r_color_pipe[0] <= (r_state == S_READ) ? rgb565_to_888(io_SRAM_DQ) : 24'd0;
      for (int i = 1; i < READ_LATENCY - 1; i++) r_color_pipe[i] <= r_color_pipe[i-1];
    end
  end

  assign o_vga_color = r_color_pipe[READ_LATENCY-2];

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Directed bench for vga_sram_arbiter with an async SRAM model and colour scoreboard.
// Expected colours are queued with a due cycle; a negedge monitor pops and compares.
// Writes reaching the SRAM are logged for address/timing checks.
module tb_vga_sram_arbiter;

  localparam int H_SIZE = 1600;
  localparam int V_SIZE = 900;
  localparam int SHIFT  = 1;
  localparam int FB_W   = H_SIZE >> SHIFT;
  localparam int FB_H   = V_SIZE >> SHIFT;

  initial begin
    if (FB_W * FB_H > (1 << 20)) $fatal(1, "frame buffer larger than SRAM");
  end

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] vga_H = '0;
  logic [10:0] vga_V = '0;
  logic        vga_valid = 1'b0;
  logic [23:0] vga_color;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [11:0] wr_x = '0;
  logic [10:0] wr_y = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] drop_cnt;
  logic [19:0] addr;
  wire  [15:0] sram_dq;
  logic        we_n, ce_n, oe_n, lb_n, ub_n;

  vga_sram_arbiter #(
    .H_SIZE(H_SIZE), .V_SIZE(V_SIZE), .SCALE_SHIFT(SHIFT), .READ_LATENCY(2)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_vga_H(vga_H), .i_vga_V(vga_V), .i_vga_valid(vga_valid), .o_vga_color(vga_color),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_x(wr_x), .i_wr_y(wr_y),
    .i_wr_data(wr_data), .o_wr_drop_count(drop_cnt),
    .o_SRAM_ADDR(addr), .io_SRAM_DQ(sram_dq), .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n),
    .o_SRAM_OE_N(oe_n), .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Async SRAM model: drives DQ while selected for read.
  bit [15:0] mem [0:(1<<20)-1];
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[addr] : 16'hzzzz;

  typedef struct { int due; logic [23:0] color; } exp_t;
  typedef struct { int cyc; logic [19:0] addr; logic [15:0] dat; } wev_t;
  exp_t exp_q[$];
  wev_t we_q[$];
  exp_t mon_e;

  int n_chk = 0;
  int n_fail = 0;
  int contention = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: SRAM write capture, contention watch, colour scoreboard.
  always @(negedge clk) begin
    if (rst_n && !ce_n && !we_n) begin
      mem[addr] = sram_dq;
      we_q.push_back('{cyc: cyc, addr: addr, dat: sram_dq});
    end
    if (!we_n && !oe_n) contention++;
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      chk("rd_color", {8'h0, vga_color}, {8'h0, mon_e.color});
    end else begin
      chk("idle_color", {8'h0, vga_color}, 32'h0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [11:0] h, input logic [10:0] v, input logic [23:0] e);
    vga_H = h; vga_V = v; vga_valid = 1'b1;
    exp_q.push_back('{due: cyc + 2, color: e});
    @(negedge clk);
    vga_valid = 1'b0;
  endtask

  task automatic wr(input logic [11:0] x, input logic [10:0] y, input logic [15:0] d);
    int n;
    wr_x = x; wr_y = y; wr_data = d; wr_valid = 1'b1;
    n = 0;
    while (!wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wr_ready_wait", {31'h0, wr_ready}, 32'h1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  int n0, r0;

  initial begin
    // Reset values
    idle(3);
    chk("rst_color", {8'h0, vga_color}, 32'h0);
    chk("rst_ready", {31'h0, wr_ready}, 32'h1);
    chk("rst_drop", {16'h0, drop_cnt}, 32'h0);
    chk("rst_addr", {12'h0, addr}, 32'h0);
    chk("rst_we_n", {31'h0, we_n}, 32'h1);
    chk("rst_oe_n", {31'h0, oe_n}, 32'h1);
    chk("rst_ce_n", {31'h0, ce_n}, 32'h1);
    chk("rst_lbub", {30'h0, lb_n, ub_n}, 32'h3);
    rst_n = 1'b1;
    idle(2);

    // Basic write then replicated reads
    wr(1, 1, 16'hF800);
    rd(1, 1, 24'hFF0000);
    chk("rd_ce_low", {31'h0, ce_n}, 32'h0);
    rd(2, 2, 24'hFF0000);
    idle(3);

    // Back-to-back writes, far-corner address
    n0 = we_q.size();
    wr(1, 2, 16'h001F);
    wr(2, 2, 16'hAAAA);
    wr(800, 450, 16'h07E0);
    idle(2);
    chk("b2b_count", we_q.size(), n0 + 3);
    chk("b2b_cyc1", we_q[n0+1].cyc, we_q[n0].cyc + 1);
    chk("b2b_cyc2", we_q[n0+2].cyc, we_q[n0+1].cyc + 1);
    chk("corner_addr", {12'h0, we_q[n0+2].addr}, 32'd359999);
    chk("corner_dat", {16'h0, we_q[n0+2].dat}, 32'h07E0);
    rd(1600, 900, 24'h00FF00);
    idle(3);

    // Read directly after a write
    wr(3, 3, 16'h8410);
    rd(5, 5, 24'h848284);
    idle(3);

    // Writes held off by 10 continuous reads
    n0 = we_q.size();
    r0 = cyc;
    fork
      begin
        wr(5, 5, 16'h001F);
        wr(7, 7, 16'hABCD);
      end
      begin
        for (int k = 0; k < 10; k++) begin
          if (k > 0) chk("ready_blocked", {31'h0, wr_ready}, 32'h0);
          rd(1, 1, 24'hFF0000);
        end
      end
    join
    idle(3);
    chk("blk_count", we_q.size(), n0 + 2);
    chk("blk_first_cyc", we_q[n0].cyc, r0 + 11);
    chk("blk_first_addr", {12'h0, we_q[n0].addr}, 32'd3204);
    chk("blk_second_cyc", we_q[n0+1].cyc, r0 + 12);
    chk("blk_second_addr", {12'h0, we_q[n0+1].addr}, 32'd4806);
    rd(9, 9, 24'h0000FF);
    rd(13, 13, 24'hAD796B);
    idle(3);

    // Out-of-range writes are dropped
    n0 = we_q.size();
    wr(0, 5, 16'h1111);
    chk("drop_ce_n", {31'h0, ce_n}, 32'h1);
    chk("drop_ready", {31'h0, wr_ready}, 32'h1);
    wr(801, 1, 16'h2222);
    chk("drop_ce_n", {31'h0, ce_n}, 32'h1);
    wr(1, 451, 16'h3333);
    chk("drop_ce_n", {31'h0, ce_n}, 32'h1);
    idle(2);
    chk("drop_count", {16'h0, drop_cnt}, 32'd3);
    chk("drop_no_we", we_q.size(), n0);
    chk("drop_ready_end", {31'h0, wr_ready}, 32'h1);

    // Out-of-range reads: no strobe, zero colour
    rd(0, 1, 24'h0);
    chk("oob_ce_n", {31'h0, ce_n}, 32'h1);
    rd(1601, 5, 24'h0);
    chk("oob_ce_n", {31'h0, ce_n}, 32'h1);
    rd(5, 901, 24'h0);
    chk("oob_ce_n", {31'h0, ce_n}, 32'h1);
    idle(3);

    // Reset in the middle of a write cycle
    wr(10, 10, 16'h1234);
    idle(3);
    wr_x = 10; wr_y = 10; wr_data = 16'hFFFF; wr_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_we_low", {31'h0, we_n}, 32'h0);
    rst_n = 1'b0;
    wr_valid = 1'b0;
    #1;
    chk("async_we_n", {31'h0, we_n}, 32'h1);
    chk("async_ce_n", {31'h0, ce_n}, 32'h1);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    chk("post_rst_drop", {16'h0, drop_cnt}, 32'h0);
    chk("post_rst_ready", {31'h0, wr_ready}, 32'h1);
    rd(19, 19, 24'h1045A5);
    idle(4);

    chk("queue_drained", exp_q.size(), 0);
    chk("dq_contention", contention, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
